// File: rtl/sram_bus_responder.sv
// Behavioural stand-in for the SRAM controller plus 64-bit SRAM: programmable wait states,
// a 32-bit word store, and aligned-pair doubleword reads with a sticky out-of-range flag.
module sram_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          DEPTH_WORDS = 1024,  // power of two, >= 2
    parameter int          LATENCY     = 5      // BUSY cycles per transaction, 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [31:0] addr,
    input  logic [31:0] st_val,
    output logic [63:0] read_data,
    output logic        ready,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_is_write;
    logic [63:0]   r_read_data;
    logic          r_addr_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [31:0]   w_idx;
    logic          w_in_range;
    logic [AW-1:0] w_word;
    logic [AW-1:0] w_lo;
    logic [AW-1:0] w_hi;
    logic          w_req;
    logic          w_commit;

    // Decode works on the captured address so the access is immune to bus changes during BUSY.
    assign w_idx      = (r_addr - BASE_ADDR) >> 2;
    assign w_in_range = (r_addr >= BASE_ADDR) && (w_idx < 32'(DEPTH_WORDS));
    assign w_word     = w_idx[AW-1:0];
    assign w_lo       = w_word & ~AW'(1);
    assign w_hi       = w_word | AW'(1);
    assign w_req      = write_en | read_en;
    assign w_commit   = (r_state == S_BUSY) && (r_cnt == 4'd0);

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_is_write  <= 1'b0;
            r_read_data <= 64'd0;
            r_addr_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr     <= addr;
                        r_wdata    <= st_val;
                        r_is_write <= write_en;  // write wins when both are raised
                        r_cnt      <= 4'(LATENCY - 1);
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        if (!w_in_range) begin
                            r_addr_err <= 1'b1;
                        end
                        if (!r_is_write) begin
                            r_read_data <= w_in_range ? {r_mem[w_hi], r_mem[w_lo]} : 64'd0;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the word array deliberately has no reset so it maps onto plain RAM and keeps its
    // contents across rst; a reset mid-BUSY forces IDLE, which suppresses w_commit.
    always_ff @(posedge clk) begin
        if (w_commit && r_is_write && w_in_range) begin
            r_mem[w_word] <= r_wdata;
        end
    end

    assign ready     = (r_state == S_IDLE) ? ~w_req : (r_state == S_DONE);
    assign read_data = r_read_data;
    assign addr_err  = r_addr_err;

endmodule
